// File: rtl/ecg_alg_pkg.sv
// Shared types and helpers for the ECG R-peak detector.
package ecg_alg_pkg;

   typedef enum logic {
      ST_BELOW = 1'b0,
      ST_ABOVE = 1'b1
   } det_state_e;

   // Exact log2 for the power-of-two averaging lengths.
   function automatic int log2_int(input int n);
      int r;
      r = 0;
      while ((1 << r) < n) r++;
      return r;
   endfunction

endpackage

// File: rtl/ecg_moving_avg.sv
// Running-sum moving average over the last N accepted samples.
module ecg_moving_avg
   import ecg_alg_pkg::*;
#(
   parameter int WIDTH = 11,
   parameter int N     = 16
) (
   input  logic             i_clk,
   input  logic             i_nrst,
   input  logic             i_accept,
   input  logic [WIDTH-1:0] i_sample,
   output logic [WIDTH-1:0] o_ma,
   output logic             o_valid
);

   localparam int SHIFT = log2_int(N);
   localparam int SUM_W = WIDTH + SHIFT;
   localparam int CNT_W = SHIFT + 1;

   logic [WIDTH-1:0] dline_q [N];
   logic [WIDTH-1:0] dline_d [N];
   logic [SUM_W-1:0] sum_q, sum_d;
   logic [WIDTH-1:0] ma_q, ma_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             valid_q, valid_d;

   // The delay line starts cleared, so the tail reads 0 until the window fills.
   always_comb begin
      dline_d = dline_q;
      sum_d   = sum_q;
      ma_d    = ma_q;
      cnt_d   = cnt_q;
      valid_d = valid_q;
      if (i_accept) begin
         dline_d[0] = i_sample;
         for (int i = 1; i < N; i++) begin
            dline_d[i] = dline_q[i-1];
         end
         sum_d = sum_q + SUM_W'(i_sample) - SUM_W'(dline_q[N-1]);
         ma_d  = sum_d[SHIFT +: WIDTH];
         if (cnt_q != CNT_W'(N)) begin
            cnt_d = cnt_q + 1'b1;
         end
         if (cnt_q == CNT_W'(N - 1)) begin
            valid_d = 1'b1;
         end
      end
   end

   always_ff @(posedge i_clk) begin
      if (!i_nrst) begin
         for (int i = 0; i < N; i++) begin
            dline_q[i] <= '0;
         end
         sum_q   <= '0;
         ma_q    <= '0;
         cnt_q   <= '0;
         valid_q <= 1'b0;
      end else begin
         dline_q <= dline_d;
         sum_q   <= sum_d;
         ma_q    <= ma_d;
         cnt_q   <= cnt_d;
         valid_q <= valid_d;
      end
   end

   assign o_ma    = ma_q;
   assign o_valid = valid_q;

endmodule

// File: rtl/ecg_alg_core.sv
// R-peak detector: rectified short/long moving averages, adaptive threshold,
// peak location and RR-period reporting.
module ecg_alg_core
   import ecg_alg_pkg::*;
#(
   parameter int DATA_WIDTH   = 11,
   parameter int CTR_WIDTH    = 22,
   parameter int DATA_OFFSET  = 1024,
   parameter int NAVG_SHORT   = 16,
   parameter int NAVG_LONG    = 32,
   parameter int INIT_SAMPLES = 360,
   parameter int REFRACTORY   = 72
) (
   input  logic                  i_clk,
   input  logic                  i_nrst,
   input  logic                  i_ce,
   input  logic [DATA_WIDTH-1:0] i_ecg_signal,
   input  logic                  i_ecg_signal_valid,
   input  logic [CTR_WIDTH-1:0]  i_ctr,
   output logic [DATA_WIDTH-1:0] o_rr_period,
   output logic                  o_rr_period_updated,
   output logic [CTR_WIDTH-1:0]  o_rpeak_location,
   output logic                  o_ma_short_valid,
   output logic                  o_ma_long_valid,
   output logic                  o_th_initialised,
   output logic                  o_alg_active
);

   localparam int INIT_W = $clog2(INIT_SAMPLES + 1);
   localparam int REF_W  = $clog2(REFRACTORY + 1);
   localparam logic [CTR_WIDTH-1:0] RR_MAX  = CTR_WIDTH'((1 << DATA_WIDTH) - 1);
   localparam logic [CTR_WIDTH-1:0] LOC_ADJ = CTR_WIDTH'(NAVG_SHORT / 2);

   logic                         accept;
   logic signed [DATA_WIDTH:0]   x;
   logic [DATA_WIDTH-1:0]        rect;
   logic [DATA_WIDTH-1:0]        ma_short, ma_long;
   logic                         ma_short_valid, ma_long_valid;
   logic [DATA_WIDTH:0]          th_sum;
   logic [DATA_WIDTH-1:0]        th;
   logic [DATA_WIDTH+1:0]        pk_sum;
   logic [CTR_WIDTH-1:0]         loc, rr_diff;

   det_state_e                   state_q, state_d;
   logic                         th_init_q, th_init_d;
   logic [INIT_W-1:0]            init_cnt_q, init_cnt_d;
   logic [DATA_WIDTH-1:0]        peak_q, peak_d;
   logic [DATA_WIDTH-1:0]        cand_max_q, cand_max_d;
   logic [CTR_WIDTH-1:0]         cand_loc_q, cand_loc_d;
   logic [REF_W-1:0]             ref_q, ref_d;
   logic [CTR_WIDTH-1:0]         prev_loc_q, prev_loc_d;
   logic                         have_prev_q, have_prev_d;
   logic [CTR_WIDTH-1:0]         rpeak_q, rpeak_d;
   logic [DATA_WIDTH-1:0]        rr_q, rr_d;
   logic                         rr_upd_q, rr_upd_d;

   assign accept = i_ce & i_ecg_signal_valid;

   // Offset-binary to signed, then magnitude; -DATA_OFFSET still fits unsigned.
   assign x    = $signed({1'b0, i_ecg_signal}) - $signed((DATA_WIDTH+1)'(DATA_OFFSET));
   assign rect = x[DATA_WIDTH] ? DATA_WIDTH'(-x) : DATA_WIDTH'(x);

   ecg_moving_avg #(.WIDTH(DATA_WIDTH), .N(NAVG_SHORT)) u_ma_short (
      .i_clk    (i_clk),
      .i_nrst   (i_nrst),
      .i_accept (accept),
      .i_sample (rect),
      .o_ma     (ma_short),
      .o_valid  (ma_short_valid)
   );

   ecg_moving_avg #(.WIDTH(DATA_WIDTH), .N(NAVG_LONG)) u_ma_long (
      .i_clk    (i_clk),
      .i_nrst   (i_nrst),
      .i_accept (accept),
      .i_sample (rect),
      .o_ma     (ma_long),
      .o_valid  (ma_long_valid)
   );

   assign th_sum  = {1'b0, peak_q} + {1'b0, ma_long};
   assign th      = DATA_WIDTH'(th_sum >> 1);
   assign pk_sum  = {2'b00, peak_q} + {1'b0, peak_q, 1'b0} + {2'b00, cand_max_q};
   // Report the peak centred in the short window rather than at its trailing edge.
   assign loc     = cand_loc_q - LOC_ADJ;
   assign rr_diff = loc - prev_loc_q;

   always_comb begin
      state_d     = state_q;
      th_init_d   = th_init_q;
      init_cnt_d  = init_cnt_q;
      peak_d      = peak_q;
      cand_max_d  = cand_max_q;
      cand_loc_d  = cand_loc_q;
      ref_d       = ref_q;
      prev_loc_d  = prev_loc_q;
      have_prev_d = have_prev_q;
      rpeak_d     = rpeak_q;
      rr_d        = rr_q;
      rr_upd_d    = 1'b0;
      if (accept) begin
         if (!th_init_q) begin
            if (ma_long_valid) begin
               if (ma_short > peak_q) peak_d = ma_short;
               if (init_cnt_q == INIT_W'(INIT_SAMPLES - 1)) th_init_d = 1'b1;
               init_cnt_d = init_cnt_q + 1'b1;
            end
         end else begin
            if (ref_q != '0) ref_d = ref_q - 1'b1;
            case (state_q)
               ST_BELOW: begin
                  if ((ma_short > th) && (ref_q == '0)) begin
                     state_d    = ST_ABOVE;
                     cand_max_d = ma_short;
                     cand_loc_d = i_ctr;
                  end
               end
               ST_ABOVE: begin
                  if (ma_short <= th) begin
                     state_d     = ST_BELOW;
                     ref_d       = REF_W'(REFRACTORY);
                     rpeak_d     = loc;
                     peak_d      = DATA_WIDTH'(pk_sum >> 2);
                     prev_loc_d  = loc;
                     have_prev_d = 1'b1;
                     if (have_prev_q) begin
                        rr_d     = (rr_diff > RR_MAX) ? RR_MAX[DATA_WIDTH-1:0]
                                                      : rr_diff[DATA_WIDTH-1:0];
                        rr_upd_d = 1'b1;
                     end
                  end else if (ma_short > cand_max_q) begin
                     cand_max_d = ma_short;
                     cand_loc_d = i_ctr;
                  end
               end
               default: state_d = ST_BELOW;
            endcase
         end
      end
   end

   always_ff @(posedge i_clk) begin
      if (!i_nrst) begin
         state_q     <= ST_BELOW;
         th_init_q   <= 1'b0;
         init_cnt_q  <= '0;
         peak_q      <= '0;
         cand_max_q  <= '0;
         cand_loc_q  <= '0;
         ref_q       <= '0;
         prev_loc_q  <= '0;
         have_prev_q <= 1'b0;
         rpeak_q     <= '0;
         rr_q        <= '0;
         rr_upd_q    <= 1'b0;
      end else begin
         state_q     <= state_d;
         th_init_q   <= th_init_d;
         init_cnt_q  <= init_cnt_d;
         peak_q      <= peak_d;
         cand_max_q  <= cand_max_d;
         cand_loc_q  <= cand_loc_d;
         ref_q       <= ref_d;
         prev_loc_q  <= prev_loc_d;
         have_prev_q <= have_prev_d;
         rpeak_q     <= rpeak_d;
         rr_q        <= rr_d;
         rr_upd_q    <= rr_upd_d;
      end
   end

   assign o_rr_period         = rr_q;
   assign o_rr_period_updated = rr_upd_q;
   assign o_rpeak_location    = rpeak_q;
   assign o_ma_short_valid    = ma_short_valid;
   assign o_ma_long_valid     = ma_long_valid;
   assign o_th_initialised    = th_init_q;
   assign o_alg_active        = th_init_q & i_ce;

endmodule

// File: tb/tb_ecg_alg_core.sv
// Directed-vector bench for ecg_alg_core with hand-computed peak locations.
module tb_ecg_alg_core;

   localparam int DW = 11;
   localparam int CW = 22;

   logic          i_clk = 1'b0;
   logic          i_nrst = 1'b0;
   logic          i_ce = 1'b0;
   logic [DW-1:0] i_ecg_signal = '0;
   logic          i_ecg_signal_valid = 1'b0;
   logic [CW-1:0] i_ctr = '0;
   logic [DW-1:0] o_rr_period;
   logic          o_rr_period_updated;
   logic [CW-1:0] o_rpeak_location;
   logic          o_ma_short_valid;
   logic          o_ma_long_valid;
   logic          o_th_initialised;
   logic          o_alg_active;

   int total = 0;
   int bad = 0;
   int ctr_base = 0;

   ecg_alg_core dut (
      .i_clk               (i_clk),
      .i_nrst              (i_nrst),
      .i_ce                (i_ce),
      .i_ecg_signal        (i_ecg_signal),
      .i_ecg_signal_valid  (i_ecg_signal_valid),
      .i_ctr               (i_ctr),
      .o_rr_period         (o_rr_period),
      .o_rr_period_updated (o_rr_period_updated),
      .o_rpeak_location    (o_rpeak_location),
      .o_ma_short_valid    (o_ma_short_valid),
      .o_ma_long_valid     (o_ma_long_valid),
      .o_th_initialised    (o_th_initialised),
      .o_alg_active        (o_alg_active)
   );

   always #5 i_clk = ~i_clk;

   // Baseline 1024 with 5-sample spikes of 1624 at offset 100 of every period.
   function automatic int ecg_value(input int n, input int period);
      int ph;
      ph = n % period;
      return ((ph >= 100) && (ph < 105)) ? 1624 : 1024;
   endfunction

   task automatic apply_reset();
      i_nrst = 1'b0;
      i_ce = 1'b1;
      i_ecg_signal_valid = 1'b0;
      repeat (3) @(posedge i_clk);
      #1;
      i_nrst = 1'b1;
   endtask

   task automatic send(input int value, input int n);
      i_ce = 1'b1;
      i_ecg_signal = DW'(value);
      i_ecg_signal_valid = 1'b1;
      i_ctr = CW'(ctr_base + n);
      @(posedge i_clk);
      #1;
   endtask

   task automatic test_reset();
      i_nrst = 1'b0;
      i_ce = 1'b1;
      i_ecg_signal = DW'(1624);
      i_ecg_signal_valid = 1'b1;
      repeat (3) @(posedge i_clk);
      #1;
      total++; if (o_rr_period !== '0) begin bad++; $display("FAIL rst_rr got=%0d exp=0", o_rr_period); end
      total++; if (o_rr_period_updated !== 1'b0) begin bad++; $display("FAIL rst_upd got=%0b exp=0", o_rr_period_updated); end
      total++; if (o_rpeak_location !== '0) begin bad++; $display("FAIL rst_loc got=%0d exp=0", o_rpeak_location); end
      total++; if ({o_ma_short_valid, o_ma_long_valid, o_th_initialised, o_alg_active} !== 4'b0000) begin
         bad++; $display("FAIL rst_flags got=%b exp=0000", {o_ma_short_valid, o_ma_long_valid, o_th_initialised, o_alg_active});
      end
      i_nrst = 1'b1;
      i_ecg_signal_valid = 1'b0;
      repeat (4) @(posedge i_clk);
      #1;
      total++; if ({o_ma_short_valid, o_ma_long_valid, o_th_initialised, o_alg_active} !== 4'b0000) begin
         bad++; $display("FAIL idle_flags got=%b exp=0000", {o_ma_short_valid, o_ma_long_valid, o_th_initialised, o_alg_active});
      end
   endtask

   task automatic test_const_zero();
      ctr_base = 0;
      apply_reset();
      for (int n = 0; n < 500; n++) begin
         send(1024, n);
         total++; if (o_ma_short_valid !== (n >= 15)) begin bad++; $display("FAIL zero_sv n=%0d got=%0b exp=%0b", n, o_ma_short_valid, n >= 15); end
         total++; if (o_ma_long_valid !== (n >= 31)) begin bad++; $display("FAIL zero_lv n=%0d got=%0b exp=%0b", n, o_ma_long_valid, n >= 31); end
         total++; if (o_th_initialised !== (n >= 391)) begin bad++; $display("FAIL zero_th n=%0d got=%0b exp=%0b", n, o_th_initialised, n >= 391); end
         total++; if (o_rr_period_updated !== 1'b0 || o_rpeak_location !== '0) begin
            bad++; $display("FAIL zero_det n=%0d upd=%0b loc=%0d exp upd=0 loc=0", n, o_rr_period_updated, o_rpeak_location);
         end
      end
      total++; if (o_alg_active !== 1'b1) begin bad++; $display("FAIL zero_active got=%0b exp=1", o_alg_active); end
   endtask

   task automatic test_const_100();
      ctr_base = 0;
      apply_reset();
      for (int n = 0; n < 500; n++) begin
         send(1124, n);
         total++; if (o_rr_period_updated !== 1'b0 || o_rpeak_location !== '0 || o_rr_period !== '0) begin
            bad++; $display("FAIL c100_det n=%0d upd=%0b loc=%0d rr=%0d exp all 0", n, o_rr_period_updated, o_rpeak_location, o_rr_period);
         end
      end
      total++; if (o_th_initialised !== 1'b1) begin bad++; $display("FAIL c100_th got=%0b exp=1", o_th_initialised); end
   endtask

   task automatic test_ecg();
      logic exp_upd;
      ctr_base = 0;
      apply_reset();
      for (int n = 0; n <= 1320; n++) begin
         send(ecg_value(n, 300), n);
         exp_upd = (n == 718) || (n == 1018) || (n == 1318);
         total++; if (o_rr_period_updated !== exp_upd) begin bad++; $display("FAIL ecg_upd n=%0d got=%0b exp=%0b", n, o_rr_period_updated, exp_upd); end
         if (n == 417) begin
            total++; if (o_rpeak_location !== '0) begin bad++; $display("FAIL ecg_pre_loc got=%0d exp=0", o_rpeak_location); end
         end
         if (n == 418 || n == 718 || n == 1018 || n == 1318) begin
            total++; if (o_rpeak_location !== CW'(n - 21)) begin bad++; $display("FAIL ecg_loc n=%0d got=%0d exp=%0d", n, o_rpeak_location, n - 21); end
            total++; if (o_rr_period !== ((n == 418) ? DW'(0) : DW'(300))) begin
               bad++; $display("FAIL ecg_rr n=%0d got=%0d exp=%0d", n, o_rr_period, (n == 418) ? 0 : 300);
            end
         end
      end
   endtask

   task automatic test_ce_gating();
      ctr_base = 0;
      apply_reset();
      for (int n = 0; n <= 705; n++) send(ecg_value(n, 300), n);
      // Freeze in the middle of the second beat's above-threshold run.
      for (int i = 0; i < 100; i++) begin
         i_ce = 1'b0;
         i_ecg_signal_valid = i[0];
         i_ecg_signal = DW'(1900);
         i_ctr = CW'(50000 + i);
         @(posedge i_clk);
         #1;
         total++; if (o_alg_active !== 1'b0 || o_rr_period_updated !== 1'b0) begin
            bad++; $display("FAIL ce_frozen_flags i=%0d active=%0b upd=%0b exp 0 0", i, o_alg_active, o_rr_period_updated);
         end
         total++; if (o_rpeak_location !== CW'(397) || o_rr_period !== '0 || o_th_initialised !== 1'b1) begin
            bad++; $display("FAIL ce_frozen_state i=%0d loc=%0d rr=%0d th=%0b exp 397 0 1", i, o_rpeak_location, o_rr_period, o_th_initialised);
         end
      end
      for (int n = 706; n <= 1020; n++) begin
         send(ecg_value(n, 300), n);
         total++; if (o_rr_period_updated !== ((n == 718) || (n == 1018))) begin
            bad++; $display("FAIL ce_upd n=%0d got=%0b exp=%0b", n, o_rr_period_updated, (n == 718) || (n == 1018));
         end
         if (n == 718 || n == 1018) begin
            total++; if (o_rpeak_location !== CW'(n - 21) || o_rr_period !== DW'(300)) begin
               bad++; $display("FAIL ce_resume n=%0d loc=%0d rr=%0d exp %0d 300", n, o_rpeak_location, o_rr_period, n - 21);
            end
         end
      end
      total++; if (o_alg_active !== 1'b1) begin bad++; $display("FAIL ce_active got=%0b exp=1", o_alg_active); end
   endtask

   task automatic test_saturation();
      // Counter starts 5000 below wrap so the second peak lands after wrap.
      ctr_base = (1 << CW) - 5000;
      apply_reset();
      for (int n = 0; n <= 6120; n++) begin
         send(ecg_value(n, 3000), n);
         total++; if (o_rr_period_updated !== (n == 6118)) begin bad++; $display("FAIL sat_upd n=%0d got=%0b exp=%0b", n, o_rr_period_updated, n == 6118); end
         if (n == 3118) begin
            total++; if (o_rpeak_location !== CW'(4192401) || o_rr_period !== '0) begin
               bad++; $display("FAIL sat_first loc=%0d rr=%0d exp 4192401 0", o_rpeak_location, o_rr_period);
            end
         end
         if (n == 6118) begin
            total++; if (o_rpeak_location !== CW'(1097)) begin bad++; $display("FAIL sat_loc got=%0d exp=1097", o_rpeak_location); end
            total++; if (o_rr_period !== DW'(2047)) begin bad++; $display("FAIL sat_rr got=%0d exp=2047", o_rr_period); end
         end
      end
   endtask

   initial begin
      test_reset();
      test_const_zero();
      test_const_100();
      test_ecg();
      test_ce_gating();
      test_saturation();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
